// File: rtl/arb_pkg.sv
// Shared types and helpers for the request arbiter family.
package arb_pkg;

  // Arbitration policy selector
  typedef enum logic [0:0] {
    ARB_RR    = 1'b0,
    ARB_FIXED = 1'b1
  } arb_mode_e;

  // Grant state machine encoding
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Width of a binary index into n entries, never less than one bit
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/onehot_decoder.sv
// Binary index to one-hot conversion with an enable; all zeros when disabled.
module onehot_decoder
  import arb_pkg::*;
#(
  parameter int N = 4,
  localparam int W = idx_width(N)
) (
  input  logic [W-1:0] idx,
  input  logic         en,
  output logic [N-1:0] onehot
);

  // One bit per requester, set only for the matching index when enabled
  always_comb begin
    onehot = '0;
    for (int i = 0; i < N; i++) begin
      onehot[i] = en & (idx == W'(i));
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Registered N-way arbiter: round-robin or fixed-priority, with grant lock.
module rr_arbiter
  import arb_pkg::*;
#(
  parameter int        N    = 4,
  parameter arb_mode_e MODE = ARB_RR,
  localparam int       W    = idx_width(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         hold,
  output logic [N-1:0] gnt,
  output logic [W-1:0] gnt_idx,
  output logic         gnt_valid
);

  arb_state_e   state_r, state_nxt_s;
  logic [W-1:0] ptr_r, ptr_nxt_s;
  logic [W-1:0] idx_r, idx_nxt_s;
  logic [N-1:0] gnt_r, gnt_nxt_s;
  logic [W-1:0] cand_s;
  logic [W-1:0] win_idx_s;
  logic         win_found_s;
  logic         keep_s;
  logic         sel_valid_s;

  // Lock the current grant while hold is high and its owner still requests
  assign keep_s = (state_r == GRANT) & hold & req[idx_r];

  // Winner search: wrap-around scan after ptr (RR) or lowest index (fixed)
  always_comb begin
    win_idx_s   = '0;
    win_found_s = 1'b0;
    cand_s      = ptr_r;
    if (MODE == ARB_FIXED) begin
      for (int k = N - 1; k >= 0; k--) begin
        win_idx_s   = req[k] ? W'(k) : win_idx_s;
        win_found_s = win_found_s | req[k];
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        cand_s      = (cand_s == W'(N - 1)) ? W'(0) : (cand_s + W'(1));
        win_idx_s   = (req[cand_s] & ~win_found_s) ? cand_s : win_idx_s;
        win_found_s = win_found_s | req[cand_s];
      end
    end
  end

  assign sel_valid_s = keep_s | win_found_s;

  // Next-state logic for the IDLE/GRANT machine
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    state_nxt_s = sel_valid_s ? GRANT : IDLE;
      GRANT:   state_nxt_s = sel_valid_s ? GRANT : IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Next output values: kept grant, fresh winner, or no grant
  always_comb begin
    idx_nxt_s = '0;
    ptr_nxt_s = ptr_r;
    if (keep_s) begin
      idx_nxt_s = idx_r;
      ptr_nxt_s = ptr_r;
    end else if (win_found_s) begin
      idx_nxt_s = win_idx_s;
      ptr_nxt_s = win_idx_s;
    end else begin
      idx_nxt_s = '0;
      ptr_nxt_s = ptr_r;
    end
  end

  onehot_decoder #(
    .N (N)
  ) u_dec (
    .idx    (idx_nxt_s),
    .en     (sel_valid_s),
    .onehot (gnt_nxt_s)
  );

  // State and output registers; reset parks ptr at N-1 so index 0 wins first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      ptr_r   <= W'(N - 1);
      idx_r   <= '0;
      gnt_r   <= '0;
    end else begin
      state_r <= state_nxt_s;
      ptr_r   <= ptr_nxt_s;
      idx_r   <= idx_nxt_s;
      gnt_r   <= gnt_nxt_s;
    end
  end

  assign gnt       = gnt_r;
  assign gnt_idx   = idx_r;
  assign gnt_valid = (state_r == GRANT);

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed, table-driven check of rr_arbiter in RR (N=4, N=3) and fixed mode.
module tb_rr_arbiter;
  import arb_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [3:0] req4, reqf;
  logic       hold4, holdf;
  logic [2:0] req3;
  logic       hold3;
  logic [3:0] gnt4, gntf;
  logic [1:0] idx4, idxf;
  logic       val4, valf;
  logic [2:0] gnt3;
  logic [1:0] idx3;
  logic       val3;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [3:0] req;
    logic       hold;
    logic [3:0] gnt;
    logic [1:0] idx;
    logic       valid;
  } vec_t;

  vec_t tbl [19];

  rr_arbiter #(.N(4), .MODE(ARB_RR)) u_rr4 (
    .clk(clk), .rst_n(rst_n), .req(req4), .hold(hold4),
    .gnt(gnt4), .gnt_idx(idx4), .gnt_valid(val4)
  );

  rr_arbiter #(.N(4), .MODE(ARB_FIXED)) u_fx4 (
    .clk(clk), .rst_n(rst_n), .req(reqf), .hold(holdf),
    .gnt(gntf), .gnt_idx(idxf), .gnt_valid(valf)
  );

  rr_arbiter #(.N(3), .MODE(ARB_RR)) u_rr3 (
    .clk(clk), .rst_n(rst_n), .req(req3), .hold(hold3),
    .gnt(gnt3), .gnt_idx(idx3), .gnt_valid(val3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // req, hold -> gnt, idx, valid  (N=4 RR, starting from reset)
    tbl[0]  = '{4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1};
    tbl[1]  = '{4'b1111, 1'b0, 4'b0010, 2'd1, 1'b1};
    tbl[2]  = '{4'b1111, 1'b0, 4'b0100, 2'd2, 1'b1};
    tbl[3]  = '{4'b1111, 1'b0, 4'b1000, 2'd3, 1'b1};
    tbl[4]  = '{4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1};
    tbl[5]  = '{4'b1010, 1'b0, 4'b0010, 2'd1, 1'b1};
    tbl[6]  = '{4'b1010, 1'b0, 4'b1000, 2'd3, 1'b1};
    tbl[7]  = '{4'b1010, 1'b0, 4'b0010, 2'd1, 1'b1};
    tbl[8]  = '{4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0};
    tbl[9]  = '{4'b0011, 1'b1, 4'b0001, 2'd0, 1'b1};
    tbl[10] = '{4'b0011, 1'b1, 4'b0001, 2'd0, 1'b1};
    tbl[11] = '{4'b0011, 1'b1, 4'b0001, 2'd0, 1'b1};
    tbl[12] = '{4'b0011, 1'b1, 4'b0001, 2'd0, 1'b1};
    tbl[13] = '{4'b0011, 1'b1, 4'b0001, 2'd0, 1'b1};
    tbl[14] = '{4'b0010, 1'b1, 4'b0010, 2'd1, 1'b1};
    tbl[15] = '{4'b0110, 1'b1, 4'b0010, 2'd1, 1'b1};
    tbl[16] = '{4'b0110, 1'b0, 4'b0100, 2'd2, 1'b1};
    tbl[17] = '{4'b0001, 1'b1, 4'b0001, 2'd0, 1'b1};
    tbl[18] = '{4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1};

    rst_n = 1'b0;
    req4 = 4'b0000; hold4 = 1'b0;
    reqf = 4'b0000; holdf = 1'b0;
    req3 = 3'b000;  hold3 = 1'b0;

    // Reset state, observed before any clock edge
    #2;
    check("rst_gnt4", 32'(gnt4), 32'd0);
    check("rst_idx4", 32'(idx4), 32'd0);
    check("rst_val4", 32'(val4), 32'd0);
    check("rst_gntf", 32'(gntf), 32'd0);
    check("rst_gnt3", 32'(gnt3), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven RR sequences on N=4
    for (int i = 0; i < 19; i++) begin
      req4  = tbl[i].req;
      hold4 = tbl[i].hold;
      step();
      check($sformatf("rr4_gnt[%0d]", i), 32'(gnt4), 32'(tbl[i].gnt));
      check($sformatf("rr4_idx[%0d]", i), 32'(idx4), 32'(tbl[i].idx));
      check($sformatf("rr4_val[%0d]", i), 32'(val4), 32'(tbl[i].valid));
    end

    // Mid-grant asynchronous reset: ptr is 3 after the table
    req4 = 4'b1111; hold4 = 1'b0;
    step(); check("pre_rst_a", 32'(gnt4), 32'b0001);
    step(); check("pre_rst_b", 32'(gnt4), 32'b0010);
    step(); check("pre_rst_c", 32'(gnt4), 32'b0100);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_gnt", 32'(gnt4), 32'd0);
    check("async_rst_val", 32'(val4), 32'd0);
    #1 rst_n = 1'b1;
    step(); check("post_rst_gnt", 32'(gnt4), 32'b0001);
    check("post_rst_idx", 32'(idx4), 32'd0);
    req4 = 4'b0000;

    // Fixed priority: lowest index wins, no rotation
    reqf = 4'b1110;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("fx_gnt[%0d]", i), 32'(gntf), 32'b0010);
      check($sformatf("fx_idx[%0d]", i), 32'(idxf), 32'd1);
    end
    reqf = 4'b1100;
    step(); check("fx_gnt_1100", 32'(gntf), 32'b0100);
    reqf = 4'b0000;
    step(); check("fx_val_idle", 32'(valf), 32'd0);
    check("fx_gnt_idle", 32'(gntf), 32'd0);

    // N=3 RR: wrap from index 2 back to 0, index never reaches 3
    req3 = 3'b111;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("rr3_gnt[%0d]", i), 32'(gnt3), 32'(3'b001 << (i % 3)));
      check($sformatf("rr3_idx[%0d]", i), 32'(idx3), 32'(i % 3));
    end
    req3 = 3'b101;
    step(); check("rr3_gnt_101", 32'(gnt3), 32'b100);
    step(); check("rr3_gnt_wrap", 32'(gnt3), 32'b001);
    req3 = 3'b000;
    step(); check("rr3_val_idle", 32'(val3), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
